// File: rtl/arb_pkg.sv
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared types and helpers for the round-robin burst arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

  typedef enum logic {IDLE, OWN} arb_state_t;

  // Widest requester vector the index encoder accepts.
  localparam int unsigned ARB_MAX_N = 256;

  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Circular first-set-bit search starting at ptr, via double-width
//           rotate, lowest-bit isolate and rotate back.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   vec,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [N-1:0]           rot;
  logic [N-1:0]           rot_win;
  logic [ARB_MAX_N-1:0]   ext;

  always_comb begin
    rot     = N'({vec, vec} >> ptr);
    rot_win = rot & (~rot + N'(1));
    onehot  = N'(({rot_win, rot_win} << ptr) >> N);
    ext     = '0;
    ext[N-1:0] = onehot;
    idx     = IDW'(onehot_to_idx(ext));
  end

  assign any = |vec;

endmodule

`default_nettype wire

// File: rtl/rr_burst_arbiter.sv
// ============================================================================
// Module  : rr_burst_arbiter
// Brief   : Round-robin arbiter with burst grant locking and bubble-free
//           handover. Optional macro ARB_TIMEOUT_EN adds a beat limit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int MAX_BEATS = 16,
  localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_last,
  input  logic           ack,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic           timeout
`endif
);

  localparam int unsigned W1 = IDW + 1;

  if (N < 1 || MAX_BEATS < 1) begin : g_param_check
    $error("rr_burst_arbiter: N and MAX_BEATS must be >= 1");
  end

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nx;
  logic [IDW:0]   inc;
  logic [N-1:0]   pick_vec;
  logic [N-1:0]   pick_oh;
  logic [IDW-1:0] pick_ptr;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           own_req;
  logic           own_last;
  logic           beat;
  logic           rel;
  logic           force_rel;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_BEATS + 1);
  logic [CW-1:0] beat_cnt;
`endif

  always_comb begin
    own_req   = req[gnt_id];
    own_last  = req_last[gnt_id];
    beat      = ack & own_req;
    force_rel = 1'b0;
`ifdef ARB_TIMEOUT_EN
    force_rel = beat & ~own_last & (beat_cnt == CW'(MAX_BEATS - 1));
`endif
    rel    = (beat & own_last) | ~own_req | force_rel;
    inc    = {1'b0, gnt_id} + W1'(1);
    ptr_nx = (inc >= W1'(N)) ? '0 : inc[IDW-1:0];
    // While owning, the search runs as if the release already happened.
    if (state == OWN) begin
      pick_vec = req & ~gnt;
      pick_ptr = ptr_nx;
    end else begin
      pick_vec = req;
      pick_ptr = ptr;
    end
  end

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .vec    (pick_vec),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
      ptr    <= '0;
`ifdef ARB_TIMEOUT_EN
      beat_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            state  <= OWN;
            gnt    <= pick_oh;
            gnt_id <= pick_idx;
            busy   <= 1'b1;
          end
        end
        OWN: begin
`ifdef ARB_TIMEOUT_EN
          if (beat && beat_cnt != CW'(MAX_BEATS)) beat_cnt <= beat_cnt + CW'(1);
`endif
          if (rel) begin
            ptr <= ptr_nx;
`ifdef ARB_TIMEOUT_EN
            beat_cnt <= '0;
            timeout  <= force_rel;
`endif
            if (pick_any) begin
              gnt    <= pick_oh;
              gnt_id <= pick_idx;
            end else begin
              state  <= IDLE;
              gnt    <= '0;
              gnt_id <= '0;
              busy   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
// ============================================================================
// Module  : tb_rr_burst_arbiter
// Brief   : Scoreboard bench for rr_burst_arbiter; honours ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_burst_arbiter;

  localparam int N      = 8;
  localparam int IDW    = 3;
  localparam int TB_MAX = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic           ack;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  always #5 clk = ~clk;

  rr_burst_arbiter #(.N(N), .MAX_BEATS(TB_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_last (req_last),
    .ack      (ack),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );
`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]   g;
    logic [IDW-1:0] id;
    logic           b;
    logic           t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: owner index (-1 = idle), rotation start and beats taken.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  bit m_to    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [N-1:0] v, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (v[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lst,
                       input logic a);
    exp_t e;
    int   o;
    bit   bt, forced, rel;
    m_to = 0;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_beats = 0;
    end else if (m_owner < 0) begin
      m_owner = find(rq, m_ptr, -1);
    end else begin
      o  = m_owner;
      bt = a && rq[o];
      if (bt) m_beats++;
      forced = TO_EN && bt && !lst[o] && (m_beats >= TB_MAX);
      rel    = (bt && lst[o]) || !rq[o] || forced;
      if (rel) begin
        m_ptr   = (o + 1) % N;
        m_beats = 0;
        m_to    = forced;
        m_owner = find(rq, m_ptr, o);
      end
    end
    e.g  = (m_owner < 0) ? '0 : N'(1) << m_owner;
    e.id = (m_owner < 0) ? '0 : IDW'(m_owner);
    e.b  = (m_owner >= 0);
    e.t  = m_to;
    q.push_back(e);
  endtask

  // Drive on the falling edge, predict, then return just after the rising edge.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lst,
                      input logic a);
    @(negedge clk);
    reset = r; req = rq; req_last = lst; ack = a;
    model(r, rq, lst, a);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_gnt",    32'(gnt),     32'(e.g));
        chk("sb_gnt_id", 32'(gnt_id),  32'(e.id));
        chk("sb_busy",   32'(busy),    32'(e.b));
        chk("sb_timeout", 32'(timeout), 32'(e.t));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [N-1:0] rq;
    reset = 1'b1; req = '0; req_last = '0; ack = 1'b0;

    // Reset state
    step(1, '0, '0, 0);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_busy", 32'(busy), 0);

    // Two requesters alternate with single-beat bursts
    step(0, 8'h05, 8'h05, 1);
    for (int i = 0; i < 6; i++) begin
      chk("alt_id", 32'(gnt_id), (i % 2 == 0) ? 0 : 2);
      step(0, 8'h05, 8'h05, 1);
    end

    // Owner 3 four-beat burst, requester 5 queued behind it
    step(1, '0, '0, 0);
    step(0, 8'h08, 8'h00, 0);
    chk("burst_own3", 32'(gnt), 32'h08);
    step(0, 8'h08, 8'h00, 1);
    step(0, 8'h28, 8'h00, 0);
    step(0, 8'h28, 8'h00, 1);
    step(0, 8'h28, 8'h00, 1);
    chk("burst_hold", 32'(gnt), 32'h08);
    step(0, 8'h28, 8'h08, 1);
    chk("burst_handover", 32'(gnt), 32'h20);

    // All eight requesting: strict rotation
    step(1, '0, '0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'hFF, 8'hFF, 1);
      chk("rot_id", 32'(gnt_id), 32'(i % 8));
    end

    // Owner 6 abandons its burst, then the pointer favours 7
    step(1, '0, '0, 0);
    step(0, 8'h40, 8'h00, 1);
    chk("abandon_own6", 32'(gnt_id), 6);
    step(0, 8'h00, 8'h00, 0);
    chk("abandon_idle", 32'(busy), 0);
    step(0, 8'h81, 8'h00, 0);
    chk("abandon_ptr7", 32'(gnt_id), 7);

    // Reset in the middle of a burst
    step(1, '0, '0, 0);
    step(0, 8'h04, 8'h00, 1);
    step(1, 8'h04, 8'h00, 1);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_id", 32'(gnt_id), 0);
    step(0, 8'h06, 8'h00, 0);
    chk("midrst_ptr0", 32'(gnt_id), 1);

`ifdef ARB_TIMEOUT_EN
    // Forced release after the beat limit
    step(1, '0, '0, 0);
    step(0, 8'h02, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h12, 8'h00, 1);
    chk("to_hold", 32'(gnt), 32'h02);
    chk("to_quiet", 32'(timeout), 0);
    step(0, 8'h12, 8'h00, 1);
    chk("to_pulse", 32'(timeout), 1);
    chk("to_handover", 32'(gnt), 32'h10);
    step(0, 8'h10, 8'h00, 0);
    chk("to_once", 32'(timeout), 0);
`endif

    // Randomised traffic with sticky requests
    step(1, '0, '0, 0);
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i]) begin
          if ($urandom_range(7) == 0) rq[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          rq[i] = 1'b1;
        end
      end
      step(($urandom_range(199) == 0), rq, N'($urandom) & N'($urandom),
           ($urandom_range(3) != 0));
    end

    @(negedge clk);
    chk("sb_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
